// File: rtl/useq_pkg.sv
// Shared types and constants for the useq_control microsequencer.
// Holds the next-state select encoding, the microword layout and the status flag indices.
package useq_pkg;

   localparam int STATE_W_DEF = 8;
   localparam int CTRL_W_DEF  = 46;
   localparam int NSEL_W      = 3;

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_I = 2;
   localparam int FLAG_D = 3;
   localparam int FLAG_B = 4;
   localparam int FLAG_V = 6;
   localparam int FLAG_N = 7;

   localparam int INT_IRQ_BIT = 0;
   localparam int INT_NMI_BIT = 1;

   typedef enum logic [NSEL_W-1:0] {
      SEQ  = 3'd0,
      DISP = 3'd1,
      BR   = 3'd2,
      CALL = 3'd3,
      RET  = 3'd4
   } nsel_e;

   typedef struct packed {
      logic                   last;
      logic [NSEL_W-1:0]      nsel;
      logic [STATE_W_DEF-1:0] nstate;
      logic [CTRL_W_DEF-1:0]  ctrl;
   } uword_t;

   // A branch is taken when any selected flag is set and that matches the polarity.
   function automatic logic branchTaken(input logic [7:0] flags,
                                        input logic [7:0] mask,
                                        input logic       polarity);
      return (|(flags & mask)) == polarity;
   endfunction

endpackage

// File: rtl/useq_stack.sv
// Microcode return-address LIFO for useq_control.
// Only instantiated when USEQ_CALL_STACK_EN is defined; reset discards all entries.
module useq_stack
   import useq_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int W     = 8
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_data,
   output logic         o_full,
   output logic         o_empty,
   output logic [W-1:0] o_top
);

   localparam int SP_W  = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     r_mem [DEPTH];
   logic [SP_W-1:0]  r_sp;
   logic [IDX_W-1:0] w_pushIdx;
   logic [IDX_W-1:0] w_topIdx;

   assign o_full    = (r_sp == SP_W'(DEPTH));
   assign o_empty   = (r_sp == '0);
   assign w_pushIdx = IDX_W'(r_sp);
   assign w_topIdx  = o_empty ? '0 : IDX_W'(r_sp - SP_W'(1));
   assign o_top     = r_mem[w_topIdx];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sp <= '0;
      end else if (i_push && !o_full) begin
         r_sp <= r_sp + SP_W'(1);
      end else if (i_pop && !o_empty) begin
         r_sp <= r_sp - SP_W'(1);
      end
   end

   // Entry contents need no reset: the pointer alone defines what is valid.
   always_ff @(posedge clk) begin
      if (i_push && !o_full) begin
         r_mem[w_pushIdx] <= i_data;
      end
   end

endmodule

// File: rtl/useq_control.sv
// Parametrised microsequencer: microstate, latched opcode, dispatch/branch/interrupt sequencing.
// Define USEQ_CALL_STACK_EN to enable microcode CALL/RET through a return stack.
module useq_control
   import useq_pkg::*;
#(
   parameter int                 STATE_W     = 8,
   parameter int                 CTRL_W      = 46,
   parameter logic [STATE_W-1:0] RESET_STATE = STATE_W'(0),
   parameter logic [STATE_W-1:0] BR_NT_STATE = STATE_W'(11),
   parameter logic [STATE_W-1:0] BR_T_STATE  = STATE_W'(12),
   parameter logic [STATE_W-1:0] IRQ_STATE   = STATE_W'(40),
   parameter logic [STATE_W-1:0] NMI_STATE   = STATE_W'(48),
   parameter int                 I_BIT       = 2,
   parameter int                 P_WE_BIT    = 24,
   parameter logic [CTRL_W-1:0]  WE_MASK     = '0,
   parameter int                 STACK_DEPTH = 2
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rdy,
   input  logic [7:0]                    data_in,
   input  logic [7:0]                    p,
   input  logic                          irq,
   input  logic                          nmi,
   input  logic [1+3+STATE_W+CTRL_W-1:0] uword,
   input  logic [STATE_W-1:0]            op_entry,
   input  logic [7:0]                    op_flag_mask,
   input  logic                          op_polarity,
   output logic [STATE_W-1:0]            state_addr,
   output logic [7:0]                    opcode,
   output logic [CTRL_W-1:0]             ctrl_out,
   output logic [7:0]                    p_in_en,
   output logic                          sync,
   output logic [1:0]                    int_taken,
   output logic                          ustack_err
);

   localparam int UW = 1 + 3 + STATE_W + CTRL_W;

   logic [STATE_W-1:0] r_state;
   logic [7:0]         r_opcode;
   logic               r_sync;
   logic               r_nmiPend;
   logic               r_nmiPrev;
   logic [1:0]         r_intTaken;

   logic               w_last;
   logic [2:0]         w_nsel;
   logic [STATE_W-1:0] w_nstate;
   logic [CTRL_W-1:0]  w_ctrl;
   logic               w_nmiRise;
   logic               w_takeNmi;
   logic               w_takeIrq;
   logic               w_take;
   logic [STATE_W-1:0] w_seqNext;
   logic [STATE_W-1:0] w_nextState;

   assign w_last   = uword[UW-1];
   assign w_nsel   = uword[UW-2 -: 3];
   assign w_nstate = uword[CTRL_W +: STATE_W];
   assign w_ctrl   = uword[CTRL_W-1:0];

   // Interrupts are only considered at an instruction boundary; NMI wins over IRQ.
   assign w_nmiRise = nmi & ~r_nmiPrev;
   assign w_takeNmi = w_last & r_nmiPend;
   assign w_takeIrq = w_last & ~r_nmiPend & irq & ~p[I_BIT];
   assign w_take    = w_takeNmi | w_takeIrq;

`ifdef USEQ_CALL_STACK_EN
   logic               r_ustackErr;
   logic               w_errSet;
   logic               w_doPush;
   logic               w_doPop;
   logic               w_pushEn;
   logic               w_popEn;
   logic               w_stkFull;
   logic               w_stkEmpty;
   logic [STATE_W-1:0] w_stkTop;

   assign w_pushEn = rdy & ~w_take & w_doPush;
   assign w_popEn  = rdy & ~w_take & w_doPop;

   useq_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (STATE_W)
   ) uStack (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_pushEn),
      .i_pop   (w_popEn),
      .i_data  (w_nstate + STATE_W'(1)),
      .o_full  (w_stkFull),
      .o_empty (w_stkEmpty),
      .o_top   (w_stkTop)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ustackErr <= 1'b0;
      end else if (rdy && !w_take && w_errSet) begin
         r_ustackErr <= 1'b1;
      end
   end

   assign ustack_err = r_ustackErr;
`else
   logic w_unusedDepth;
   assign w_unusedDepth = (STACK_DEPTH > 0);
   assign ustack_err    = 1'b0;
`endif

   always_comb begin
      w_seqNext = w_nstate;
`ifdef USEQ_CALL_STACK_EN
      w_errSet  = 1'b0;
      w_doPush  = 1'b0;
      w_doPop   = 1'b0;
`endif
      case (w_nsel)
         DISP: w_seqNext = op_entry;
         BR:   w_seqNext = branchTaken(p, op_flag_mask, op_polarity) ? BR_T_STATE : BR_NT_STATE;
`ifdef USEQ_CALL_STACK_EN
         CALL: begin
            w_seqNext = w_nstate;
            w_doPush  = ~w_stkFull;
            w_errSet  = w_stkFull;
         end
         RET: begin
            w_doPop   = ~w_stkEmpty;
            w_errSet  = w_stkEmpty;
            w_seqNext = w_stkEmpty ? RESET_STATE : w_stkTop;
         end
`else
         CALL: w_seqNext = w_nstate;
         RET:  w_seqNext = RESET_STATE;
`endif
         default: w_seqNext = w_nstate;
      endcase

      w_nextState = w_seqNext;
      if (w_takeNmi) begin
         w_nextState = NMI_STATE;
      end else if (w_takeIrq) begin
         w_nextState = IRQ_STATE;
      end
   end

   // The NMI edge detector keeps sampling through stalls so no edge is lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= RESET_STATE;
         r_opcode   <= 8'h00;
         r_sync     <= 1'b1;
         r_nmiPend  <= 1'b0;
         r_nmiPrev  <= 1'b0;
         r_intTaken <= 2'b00;
      end else begin
         r_nmiPrev <= nmi;
         r_nmiPend <= (r_nmiPend & ~(rdy & w_takeNmi)) | w_nmiRise;
         if (rdy) begin
            r_state    <= w_nextState;
            r_sync     <= w_last & ~w_take;
            r_intTaken <= {w_takeNmi, w_takeIrq};
            if (r_sync) begin
               r_opcode <= data_in;
            end
         end
      end
   end

   always_comb begin
      ctrl_out = w_ctrl;
      p_in_en  = 8'h00;
      if (rdy) begin
         p_in_en = op_flag_mask & {8{w_ctrl[P_WE_BIT]}};
      end else begin
         ctrl_out = w_ctrl & ~WE_MASK;
      end
   end

   assign state_addr = r_state;
   assign opcode     = r_opcode;
   assign sync       = r_sync;
   assign int_taken  = r_intTaken;

endmodule

// File: tb/tb_useq_control.sv
// Scoreboard testbench for useq_control: directed scenarios followed by randomized microword streams.
// Honours USEQ_CALL_STACK_EN so the same bench covers both builds.
module tb_useq_control;

   localparam int          STATE_W = 8;
   localparam int          CTRL_W  = 46;
   localparam int          UW      = 1 + 3 + STATE_W + CTRL_W;
   localparam int          DEPTH   = 2;
   localparam logic [45:0] TB_WE_MASK = (46'd1 << 24) | (46'd1 << 5) | (46'd1 << 40);

   logic              clk;
   logic              reset;
   logic              rdy;
   logic [7:0]        data_in;
   logic [7:0]        p;
   logic              irq;
   logic              nmi;
   logic [UW-1:0]     uword;
   logic [7:0]        op_entry;
   logic [7:0]        op_flag_mask;
   logic              op_polarity;
   logic [7:0]        state_addr;
   logic [7:0]        opcode;
   logic [CTRL_W-1:0] ctrl_out;
   logic [7:0]        p_in_en;
   logic              sync;
   logic [1:0]        int_taken;
   logic              ustack_err;

   useq_control #(
      .STATE_W     (STATE_W),
      .CTRL_W      (CTRL_W),
      .WE_MASK     (TB_WE_MASK),
      .STACK_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rdy          (rdy),
      .data_in      (data_in),
      .p            (p),
      .irq          (irq),
      .nmi          (nmi),
      .uword        (uword),
      .op_entry     (op_entry),
      .op_flag_mask (op_flag_mask),
      .op_polarity  (op_polarity),
      .state_addr   (state_addr),
      .opcode       (opcode),
      .ctrl_out     (ctrl_out),
      .p_in_en      (p_in_en),
      .sync         (sync),
      .int_taken    (int_taken),
      .ustack_err   (ustack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          cycle;
      logic [7:0]  state;
      logic [7:0]  opcode;
      logic        sync;
      logic [1:0]  intTaken;
      logic        err;
      logic [45:0] ctrl;
      logic [7:0]  pEn;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;
   int   cycleNo = 0;
   logic [45:0] ctrlOr = '0;

   // Reference model: architectural state of the sequencer as the spec describes it.
   logic [7:0] mState, mOpcode;
   logic       mSync, mNmiPend, mNmiPrev, mErr;
   logic [1:0] mIntTaken;
   logic [7:0] mStack[$];

   function automatic void modelReset();
      mState = 8'd0; mOpcode = 8'h00; mSync = 1'b1; mNmiPend = 1'b0;
      mNmiPrev = 1'b0; mErr = 1'b0; mIntTaken = 2'b00;
      mStack.delete();
   endfunction

   function automatic void modelEdge(input bit rdyIn, input bit lastIn, input logic [2:0] nselIn,
                                     input logic [7:0] nstateIn, input logic [7:0] dataIn,
                                     input logic [7:0] pIn, input bit irqIn, input bit nmiIn,
                                     input logic [7:0] entryIn, input logic [7:0] maskIn,
                                     input bit polIn);
      bit         rise;
      logic [7:0] nxt;
      rise = nmiIn && !mNmiPrev;
      mNmiPrev = nmiIn;
      if (!rdyIn) begin
         if (rise) mNmiPend = 1'b1;
         return;
      end
      if (mSync) mOpcode = dataIn;
      if (lastIn && mNmiPend) begin
         mState = 8'd48; mNmiPend = rise; mIntTaken = 2'b10; mSync = 1'b0;
         return;
      end
      if (rise) mNmiPend = 1'b1;
      if (lastIn && irqIn && !pIn[2]) begin
         mState = 8'd40; mIntTaken = 2'b01; mSync = 1'b0;
         return;
      end
      mIntTaken = 2'b00;
      mSync = lastIn;
      case (nselIn)
         3'd1:    nxt = entryIn;
         3'd2:    nxt = (((pIn & maskIn) != 8'h00) == polIn) ? 8'd12 : 8'd11;
`ifdef USEQ_CALL_STACK_EN
         3'd3: begin
            if (mStack.size() == DEPTH) mErr = 1'b1;
            else mStack.push_back(nstateIn + 8'd1);
            nxt = nstateIn;
         end
         3'd4: begin
            if (mStack.size() == 0) begin
               mErr = 1'b1; nxt = 8'd0;
            end else begin
               nxt = mStack.pop_back();
            end
         end
`else
         3'd4:    nxt = 8'd0;
`endif
         default: nxt = nstateIn;
      endcase
      mState = nxt;
   endfunction

   task automatic applyStimulus(input bit rstIn, input bit rdyIn, input bit lastIn,
                                input logic [2:0] nselIn, input logic [7:0] nstateIn,
                                input logic [7:0] dataIn, input logic [7:0] pIn,
                                input bit irqIn, input bit nmiIn, input logic [7:0] entryIn,
                                input logic [7:0] maskIn, input bit polIn);
      logic [45:0] c;
      exp_t        e;
      @(negedge clk);
      c = {14'($urandom()), $urandom()} | ctrlOr;
      reset = rstIn; rdy = rdyIn; data_in = dataIn; p = pIn; irq = irqIn; nmi = nmiIn;
      uword = {lastIn, nselIn, nstateIn, c};
      op_entry = entryIn; op_flag_mask = maskIn; op_polarity = polIn;
      if (rstIn) modelReset();
      cycleNo++;
      e.cycle = cycleNo; e.state = mState; e.opcode = mOpcode; e.sync = mSync;
      e.intTaken = mIntTaken; e.err = mErr;
      e.ctrl = rdyIn ? c : (c & ~TB_WE_MASK);
      e.pEn  = rdyIn ? (maskIn & {8{c[24]}}) : 8'h00;
      expQ.push_back(e);
      if (!rstIn) modelEdge(rdyIn, lastIn, nselIn, nstateIn, dataIn, pIn, irqIn, nmiIn,
                            entryIn, maskIn, polIn);
   endtask

   task automatic checkOutput(input string name, input int cyc, input logic [63:0] act,
                              input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: compares each expected response once the DUT outputs have settled.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         while (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("state_addr", e.cycle, 64'(state_addr), 64'(e.state));
            checkOutput("opcode",     e.cycle, 64'(opcode),     64'(e.opcode));
            checkOutput("sync",       e.cycle, 64'(sync),       64'(e.sync));
            checkOutput("int_taken",  e.cycle, 64'(int_taken),  64'(e.intTaken));
            checkOutput("ustack_err", e.cycle, 64'(ustack_err), 64'(e.err));
            checkOutput("ctrl_out",   e.cycle, 64'(ctrl_out),   64'(e.ctrl));
            checkOutput("p_in_en",    e.cycle, 64'(p_in_en),    64'(e.pEn));
         end
      end
   end

   initial begin
      logic nmiLevel;
      reset = 1'b1; rdy = 1'b1; data_in = '0; p = '0; irq = 1'b0; nmi = 1'b0;
      uword = '0; op_entry = '0; op_flag_mask = '0; op_polarity = 1'b0;
      modelReset();
      $display("[TB] start");

      applyStimulus(1, 1, 0, 3'd0, 8'd0,  8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      applyStimulus(0, 1, 0, 3'd0, 8'd7,  8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      applyStimulus(0, 1, 0, 3'd0, 8'd9,  8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      applyStimulus(1, 1, 0, 3'd0, 8'd3,  8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      applyStimulus(0, 1, 0, 3'd1, 8'd0,  8'hA9, 8'h00, 0, 0, 8'h20, 8'h00, 0);
      applyStimulus(0, 1, 0, 3'd2, 8'd0,  8'h00, 8'h02, 0, 0, 8'h00, 8'h02, 1);
      applyStimulus(0, 1, 0, 3'd2, 8'd0,  8'h00, 8'h02, 0, 0, 8'h00, 8'h02, 0);
      ctrlOr = TB_WE_MASK;
      for (int i = 0; i < 3; i++)
         applyStimulus(0, 0, 0, 3'd0, 8'd99, 8'h55, 8'h00, 0, 0, 8'h00, 8'hFF, 0);
      applyStimulus(0, 1, 0, 3'd0, 8'd30, 8'h00, 8'h00, 0, 0, 8'h00, 8'hFF, 0);
      ctrlOr = '0;
      applyStimulus(0, 1, 0, 3'd0, 8'd31, 8'h00, 8'h00, 1, 1, 8'h00, 8'h00, 0);
      applyStimulus(0, 1, 1, 3'd0, 8'd32, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0);
      applyStimulus(0, 1, 1, 3'd0, 8'd33, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0);
      applyStimulus(0, 1, 1, 3'd0, 8'd34, 8'h00, 8'h04, 1, 0, 8'h00, 8'h00, 0);
      applyStimulus(0, 1, 0, 3'd3, 8'd50, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      applyStimulus(0, 1, 0, 3'd3, 8'd60, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      applyStimulus(0, 1, 0, 3'd3, 8'd70, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      for (int i = 0; i < 3; i++)
         applyStimulus(0, 1, 0, 3'd4, 8'd90, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      applyStimulus(0, 1, 0, 3'd0, 8'd1,  8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);

      nmiLevel = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) == 0) nmiLevel = ~nmiLevel;
         applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0,
                       $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
                       8'($urandom()), 8'($urandom()), 8'($urandom()),
                       $urandom_range(0, 4) == 0, nmiLevel, 8'($urandom()),
                       8'($urandom()), 1'($urandom()));
      end

      @(negedge clk);
      #4;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
